// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with round-robin or fixed-select arbitration and a registered output.
// Define STREAM_MUX_LAST_LOCK_EN to add in_last/out_last and hold the grant until a packet's last beat.
module stream_mux_rr #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SW = (N <= 2) ? 1 : $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
`ifdef STREAM_MUX_LAST_LOCK_EN
  input  logic [N-1:0]    in_last,
`endif
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_chan,
`ifdef STREAM_MUX_LAST_LOCK_EN
  output logic            out_last,
`endif
  input  logic            out_ready
);

  logic [SW-1:0] ptr;
  logic [SW-1:0] grant;
  logic          grant_valid;
  logic          load_en;
  logic          transfer;
  int            idx;

`ifdef STREAM_MUX_LAST_LOCK_EN
  logic          lock;
  logic [SW-1:0] lock_chan;
`endif

  assign load_en  = !out_valid || out_ready;
  assign transfer = rst_n && grant_valid && load_en;

  // Locked packets override everything; otherwise fixed select or a wrapping search from ptr.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    idx         = 0;
`ifdef STREAM_MUX_LAST_LOCK_EN
    if (lock) begin
      grant_valid = in_valid[lock_chan];
      grant       = lock_chan;
    end else
`endif
    if (mode) begin
      if (int'(sel) < N && in_valid[sel]) begin
        grant_valid = 1'b1;
        grant       = sel;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = (int'(ptr) + k) % N;
        if (!grant_valid && in_valid[idx]) begin
          grant_valid = 1'b1;
          grant       = SW'(idx);
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (transfer) in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else begin
      if (transfer) begin
        out_valid <= 1'b1;
        out_data  <= in_data[int'(grant)*W +: W];
        out_chan  <= grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
`ifdef STREAM_MUX_LAST_LOCK_EN
      if (transfer && !mode && in_last[grant])
`else
      if (transfer && !mode)
`endif
        ptr <= (int'(grant) == N - 1) ? '0 : grant + 1'b1;
    end
  end

`ifdef STREAM_MUX_LAST_LOCK_EN
  // A non-last beat pins the grant to its channel until that channel sends its last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock      <= 1'b0;
      lock_chan <= '0;
      out_last  <= 1'b0;
    end else if (transfer) begin
      out_last <= in_last[grant];
      if (in_last[grant]) begin
        lock <= 1'b0;
      end else begin
        lock      <= 1'b1;
        lock_chan <= grant;
      end
    end
  end
`endif

endmodule
